// File: rtl/iobuf_selftest_seq.sv
// Purpose : pad self-test sequencer for one tri-state IOBUF. Each iteration drives 0, drives 1, then releases the pad.
// Latency : start accepted on the edge it is seen in IDLE; each run lasts 3*SETTLE*ITERS+1 cycles and ends with a 1-cycle done pulse.
// Backpr. : no flow control. start is ignored while busy, and abort returns to IDLE on the next edge.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, abort    1-cycle run request (IDLE only), synchronous abort
//   io_t, io_i      IOBUF tri-state enable (1 = high-Z) and drive value
//   io_o            IOBUF pad readback (asynchronous, synchronised here)
//   busy, done      run in progress, end-of-run pulse
//   pass            err_cnt==0 for the last completed run, valid from done
//   fail_mask       sticky per-phase fail flags {rel,drv1,drv0}
//   err_cnt         saturating mismatch counter
module iobuf_selftest_seq #(
   parameter int   SETTLE        = 8,
   parameter int   ITERS         = 4,
   parameter bit   CHECK_RELEASE = 1'b1,
   parameter logic RELEASE_LEVEL = 1'b0,
   parameter int   ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             io_t,
   output logic             io_i,
   input  logic             io_o,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [2:0]       fail_mask,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int CNT_W  = (SETTLE > 2) ? $clog2(SETTLE) : 1;
   localparam int ITER_W = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE - 1);
   localparam logic [ITER_W-1:0] ITER_LAST  = ITER_W'(ITERS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRV0,
      S_DRV1,
      S_REL,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [ITER_W-1:0]   r_iter;
   logic [ITER_W-1:0]   w_iter_nxt;
   logic                r_sync1;
   logic                r_sync2;
   logic [ERR_W-1:0]    r_err_cnt;
   logic [ERR_W-1:0]    w_err_nxt;
   logic [2:0]          r_fail_mask;
   logic [2:0]          w_fail_nxt;
   logic                r_pass;
   logic                w_pass_nxt;
   logic                r_io_t;
   logic                r_io_i;
   logic                r_busy;
   logic                r_done;
   logic                w_last;
   logic [2:0]          w_mis;

   // Abort in the sample cycle discards the sample, so it also gates the compare.
   assign w_last = (r_cnt == '0) && !abort;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_iter_nxt  = r_iter;
      w_err_nxt   = r_err_cnt;
      w_fail_nxt  = r_fail_mask;
      w_pass_nxt  = r_pass;
      w_mis       = 3'b000;

      case (r_state)
         S_IDLE: begin
            // If abort and start arrive together, abort wins and nothing is cleared.
            if (start && !abort) begin
               w_state_nxt = S_DRV0;
               w_cnt_nxt   = CNT_RELOAD;
               w_iter_nxt  = '0;
               w_err_nxt   = '0;
               w_fail_nxt  = 3'b000;
               w_pass_nxt  = 1'b0;
            end
         end
         S_DRV0: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_last) begin
               w_mis[0]    = (r_sync2 != 1'b0);
               w_state_nxt = S_DRV1;
               w_cnt_nxt   = CNT_RELOAD;
            end else begin
               w_cnt_nxt   = r_cnt - 1'b1;
            end
         end
         S_DRV1: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_last) begin
               w_mis[1]    = (r_sync2 != 1'b1);
               w_state_nxt = S_REL;
               w_cnt_nxt   = CNT_RELOAD;
            end else begin
               w_cnt_nxt   = r_cnt - 1'b1;
            end
         end
         S_REL: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_last) begin
               w_mis[2]  = CHECK_RELEASE && (r_sync2 != RELEASE_LEVEL);
               w_cnt_nxt = CNT_RELOAD;
               if (r_iter == ITER_LAST) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_iter_nxt  = r_iter + 1'b1;
                  w_state_nxt = S_DRV0;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_mis != 3'b000) begin
         w_fail_nxt = r_fail_mask | w_mis;
         if (r_err_cnt != '1) begin
            w_err_nxt = r_err_cnt + 1'b1;
         end
      end

      // pass is set on entry to DONE, so it already includes the final release compare.
      if ((r_state == S_REL) && (w_state_nxt == S_DONE)) begin
         w_pass_nxt = (w_err_nxt == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_iter      <= '0;
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_err_cnt   <= '0;
         r_fail_mask <= 3'b000;
         r_pass      <= 1'b0;
         r_io_t      <= 1'b1;
         r_io_i      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_iter      <= w_iter_nxt;
         r_sync1     <= io_o;
         r_sync2     <= r_sync1;
         r_err_cnt   <= w_err_nxt;
         r_fail_mask <= w_fail_nxt;
         r_pass      <= w_pass_nxt;
         // Pad controls and status are registered from the next state so they never glitch.
         r_io_t      <= !((w_state_nxt == S_DRV0) || (w_state_nxt == S_DRV1));
         r_io_i      <= (w_state_nxt == S_DRV1);
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_DONE);
      end
   end

   assign io_t      = r_io_t;
   assign io_i      = r_io_i;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign fail_mask = r_fail_mask;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_iobuf_selftest_seq.sv
// Purpose : bench for iobuf_selftest_seq with a pad model (loopback or stuck-at-1) and a queue of expected run results.
// Latency : each run is 3*SETTLE*ITERS+1 = 25 cycles on the main instance and 49 on the narrow-counter instance.
// Backpr. : none; the bench pulses start and abort directly.
module tb_iobuf_selftest_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic       io_t;
   logic       io_i;
   logic       io_o;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] fail_mask;
   logic [7:0] err_cnt;
   int         mode;        // 0: loopback pad, 1: pad stuck at 1

   logic       start2;
   logic       abort2;
   logic       io_t2;
   logic       io_i2;
   logic       io_o2;
   logic       busy2;
   logic       done2;
   logic       pass2;
   logic [2:0] fail_mask2;
   logic [1:0] err_cnt2;

   always #5 clk = ~clk;

   // Loopback model: the pad follows io_i while driven; the pull-down gives 0 while it is released.
   assign io_o = (mode == 1) ? 1'b1 : (io_t ? 1'b0 : io_i);

   iobuf_selftest_seq #(.SETTLE(4), .ITERS(2), .CHECK_RELEASE(1'b1), .RELEASE_LEVEL(1'b0), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .io_t(io_t), .io_i(io_i), .io_o(io_o),
      .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask), .err_cnt(err_cnt)
   );

   // The narrow counter sees 8 raw mismatches in one run and must stop at 3.
   iobuf_selftest_seq #(.SETTLE(4), .ITERS(4), .CHECK_RELEASE(1'b1), .RELEASE_LEVEL(1'b0), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2),
      .io_t(io_t2), .io_i(io_i2), .io_o(io_o2),
      .busy(busy2), .done(done2), .pass(pass2), .fail_mask(fail_mask2), .err_cnt(err_cnt2)
   );

   typedef struct {
      logic       pass;
      logic [2:0] mask;
      logic [7:0] err;
      int         len;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   run_len  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: measures busy length and checks each completed run against the queue.
   always @(negedge clk) begin
      if (rst || !busy) run_len = 0;
      else              run_len++;
      if (done) begin
         if (q.size() == 0) begin
            check("unexpected_done", {31'd0, done}, 32'd0);
         end else begin
            e = q.pop_front();
            check("run_pass", {31'd0, pass}, {31'd0, e.pass});
            check("run_fail_mask", {29'd0, fail_mask}, {29'd0, e.mask});
            check("run_err_cnt", {24'd0, err_cnt}, {24'd0, e.err});
            check("run_len", run_len, e.len);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push_exp(input logic p, input logic [2:0] m, input logic [7:0] er);
      exp_t x;
      x.pass = p;
      x.mask = m;
      x.err  = er;
      x.len  = 25;
      q.push_back(x);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 200) begin
         tick();
         k++;
      end
      check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_io_t"}, {31'd0, io_t}, 32'd1);
      check({name, "_io_i"}, {31'd0, io_i}, 32'd0);
      check({name, "_busy"}, {31'd0, busy}, 32'd0);
      check({name, "_done"}, {31'd0, done}, 32'd0);
      check({name, "_pass"}, {31'd0, pass}, 32'd0);
      check({name, "_mask"}, {29'd0, fail_mask}, 32'd0);
      check({name, "_err"}, {24'd0, err_cnt}, 32'd0);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      abort  = 1'b0;
      start2 = 1'b0;
      abort2 = 1'b0;
      io_o2  = 1'b1;
      mode   = 0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // 1. Loopback: drive pattern cycle by cycle, then a clean result.
      mode = 0;
      push_exp(1'b1, 3'b000, 8'd0);
      pulse_start();
      for (int c = 1; c <= 25; c++) begin
         int  ph;
         logic et;
         logic ei;
         ph = ((c - 1) / 4) % 3;
         et = (c == 25) ? 1'b1 : (ph == 2);
         ei = (c == 25) ? 1'b0 : (ph == 1);
         check("lb_io_t", {31'd0, io_t}, {31'd0, et});
         check("lb_io_i", {31'd0, io_i}, {31'd0, ei});
         check("lb_busy", {31'd0, busy}, 32'd1);
         check("lb_done", {31'd0, done}, {31'd0, (c == 25)});
         tick();
      end
      check("lb_busy_after", {31'd0, busy}, 32'd0);
      check("lb_pass_hold", {31'd0, pass}, 32'd1);

      // 2. Stuck at 1: each iteration fails drv0 and rel.
      mode = 1;
      push_exp(1'b0, 3'b101, 8'd4);
      pulse_start();
      wait_idle("stuck1");

      // start together with abort in IDLE: nothing starts and nothing is cleared.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", {31'd0, busy}, 32'd0);
      tick();
      check("sa_busy2", {31'd0, busy}, 32'd0);
      check("sa_err", {24'd0, err_cnt}, 32'd4);
      check("sa_mask", {29'd0, fail_mask}, 32'd5);

      // 4. Abort six cycles into a stuck run; partial counts are kept and done never pulses.
      pulse_start();
      repeat (5) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_busy", {31'd0, busy}, 32'd0);
      check("ab_io_t", {31'd0, io_t}, 32'd1);
      check("ab_io_i", {31'd0, io_i}, 32'd0);
      check("ab_err", {24'd0, err_cnt}, 32'd1);
      check("ab_mask", {29'd0, fail_mask}, 32'd1);
      repeat (30) tick();
      check("ab_still_idle", {31'd0, busy}, 32'd0);

      mode = 0;
      push_exp(1'b1, 3'b000, 8'd0);
      pulse_start();
      check("rs_err_clr", {24'd0, err_cnt}, 32'd0);
      check("rs_mask_clr", {29'd0, fail_mask}, 32'd0);
      wait_idle("restart");

      // 5. start re-pulsed mid-run: run length must remain 25.
      push_exp(1'b1, 3'b000, 8'd0);
      pulse_start();
      repeat (9) tick();
      pulse_start();
      wait_idle("repulse");

      // 6. Asynchronous reset in the middle of DRV1.
      mode = 1;
      pulse_start();
      repeat (5) tick();
      check("pre_rst_err", {24'd0, err_cnt}, 32'd1);
      check("pre_rst_io_i", {31'd0, io_i}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      tick();
      rst = 1'b0;
      tick();
      mode = 0;

      // 3. Saturation on the 2-bit counter instance.
      begin
         int   k;
         logic seen;
         k    = 0;
         seen = 1'b0;
         start2 = 1'b1;
         tick();
         start2 = 1'b0;
         while (busy2 && k < 200) begin
            if (done2) begin
               seen = 1'b1;
               check("sat_err", {30'd0, err_cnt2}, 32'd3);
               check("sat_mask", {29'd0, fail_mask2}, 32'd5);
               check("sat_pass", {31'd0, pass2}, 32'd0);
            end
            tick();
            k++;
         end
         check("sat_done_seen", {31'd0, seen}, 32'd1);
         check("sat_len", k, 32'd49);
         check("sat_err_hold", {30'd0, err_cnt2}, 32'd3);
      end

      check("queue_empty", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
